// File: rtl/msrv32_pc_unit.sv
// msrv32_pc_unit: program counter, fetch address and flush control for the msrv32 pipeline.
// Ports: ms_riscv32_mp_clk_in/ms_riscv32_mp_rst_in (async active-low) clock/reset;
//   branch_taken_in, opcode_in, iaddr_in: branch/jump resolution and target;
//   ahb_ready_in: instruction bus ready (0 freezes everything);
//   trap_taken_in, trap_address_in: trap/MRET redirect;
//   pc_out, pc_plus_4_out: execute-stage PC and link value;
//   i_addr_out: fetch address; misaligned_instr_out: taken target not word aligned;
//   flush_out: kill the instruction currently being fetched.
module msrv32_pc_unit #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0000_0000
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic        branch_taken_in,
  input  logic [6:2]  opcode_in,
  input  logic [31:0] iaddr_in,
  input  logic        ahb_ready_in,
  input  logic        trap_taken_in,
  input  logic [31:0] trap_address_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus_4_out,
  output logic [31:0] i_addr_out,
  output logic        misaligned_instr_out,
  output logic        flush_out
);
  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;
  state_t state, next_state;
  logic [31:0] target, next_pc, next_pc_reg;
  logic take_branch;
  always_comb begin
    target = opcode_in == 5'b11001 ? {iaddr_in[31:1], 1'b0} : iaddr_in;
    misaligned_instr_out = state == RUN && branch_taken_in && target[1];
    // a misaligned target never redirects; the trap unit handles it
    take_branch = state == RUN && branch_taken_in && !target[1];
    pc_plus_4_out = pc_out + 32'd4;
    next_pc = trap_taken_in ? trap_address_in : take_branch ? target : pc_plus_4_out;
    i_addr_out = state == BOOT ? BOOT_ADDRESS : next_pc;
    flush_out = state != RUN;
    next_state = state;
    next_pc_reg = pc_out;
    if (ahb_ready_in) begin
      next_pc_reg = state == BOOT ? BOOT_ADDRESS : next_pc;
      next_state = state == BOOT ? RUN
                 : state == RUN ? ((trap_taken_in || take_branch) ? FLUSH : RUN)
                 : (trap_taken_in ? FLUSH : RUN);
    end
  end
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state <= BOOT;
      pc_out <= BOOT_ADDRESS;
    end else begin
      state <= next_state;
      pc_out <= next_pc_reg;
    end
  end
endmodule

// File: tb/tb_msrv32_pc_unit.sv
// tb_msrv32_pc_unit: scoreboard bench for msrv32_pc_unit with directed vectors.
module tb_msrv32_pc_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic branch_taken = 1'b0;
  logic [4:0] opcode = 5'b0;
  logic [31:0] iaddr = 32'h0;
  logic ready = 1'b0;
  logic trap_taken = 1'b0;
  logic [31:0] trap_address = 32'h0;
  logic [31:0] pc, pc4, i_addr;
  logic misaligned, flush;

  typedef struct {
    string name;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ia;
    logic fl;
    logic mis;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  msrv32_pc_unit #(.BOOT_ADDRESS(32'h0)) dut (
    .ms_riscv32_mp_clk_in(clk),
    .ms_riscv32_mp_rst_in(rst_n),
    .branch_taken_in(branch_taken),
    .opcode_in(opcode),
    .iaddr_in(iaddr),
    .ahb_ready_in(ready),
    .trap_taken_in(trap_taken),
    .trap_address_in(trap_address),
    .pc_out(pc),
    .pc_plus_4_out(pc4),
    .i_addr_out(i_addr),
    .misaligned_instr_out(misaligned),
    .flush_out(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk(e.name, "pc_out", pc, e.pc);
      chk(e.name, "pc_plus_4_out", pc4, e.pc4);
      chk(e.name, "i_addr_out", i_addr, e.ia);
      chk(e.name, "flush_out", {31'b0, flush}, {31'b0, e.fl});
      chk(e.name, "misaligned", {31'b0, misaligned}, {31'b0, e.mis});
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic rdy, input logic br,
                     input logic [4:0] op, input logic [31:0] ia, input logic tr,
                     input logic [31:0] ta, input logic [31:0] epc, input logic [31:0] epc4,
                     input logic [31:0] eia, input logic efl, input logic emis);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst;
    ready = rdy;
    branch_taken = br;
    opcode = op;
    iaddr = ia;
    trap_taken = tr;
    trap_address = ta;
    e.name = nm;
    e.pc = epc;
    e.pc4 = epc4;
    e.ia = eia;
    e.fl = efl;
    e.mis = emis;
    q.push_back(e);
  endtask

  localparam logic [4:0] BR = 5'b11000;
  localparam logic [4:0] JR = 5'b11001;

  initial begin
    //   name        rst rdy br op  iaddr         tr ta        pc            pc4           i_addr        fl mis
    cyc("reset",     0, 1, 0, 0,  32'h0,        0, 32'h0,    32'h0,        32'h4,        32'h0,        1, 0);
    cyc("boot",      1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h0,        32'h4,        32'h0,        1, 0);
    cyc("run0",      1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h0,        32'h4,        32'h4,        0, 0);
    cyc("run4",      1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h4,        32'h8,        32'h8,        0, 0);
    cyc("run8",      1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h8,        32'hC,        32'hC,        0, 0);
    cyc("runC",      1, 1, 0, 0,  32'h0,        0, 32'h0,    32'hC,        32'h10,       32'h10,       0, 0);
    cyc("branch",    1, 1, 1, BR, 32'h40,       0, 32'h0,    32'h10,       32'h14,       32'h40,       0, 0);
    cyc("flush_br",  1, 1, 1, BR, 32'h80,       0, 32'h0,    32'h40,       32'h44,       32'h44,       1, 0);
    cyc("jalr",      1, 1, 1, JR, 32'h81,       0, 32'h0,    32'h44,       32'h48,       32'h80,       0, 0);
    cyc("jalr_fl",   1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h80,       32'h84,       32'h84,       1, 0);
    cyc("misalign",  1, 1, 1, JR, 32'h82,       0, 32'h0,    32'h84,       32'h88,       32'h88,       0, 1);
    cyc("trap_win",  1, 1, 1, BR, 32'h40,       1, 32'h100,  32'h88,       32'h8C,       32'h100,      0, 0);
    cyc("trap_fl",   1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h100,      32'h104,      32'h104,      1, 0);
    cyc("to_1c",     1, 1, 1, BR, 32'h1C,       0, 32'h0,    32'h104,      32'h108,      32'h1C,       0, 0);
    cyc("fl_1c",     1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h1C,       32'h20,       32'h20,       1, 0);
    cyc("stall1",    1, 0, 1, BR, 32'h60,       0, 32'h0,    32'h20,       32'h24,       32'h60,       0, 0);
    cyc("stall2",    1, 0, 1, BR, 32'h60,       0, 32'h0,    32'h20,       32'h24,       32'h60,       0, 0);
    cyc("stall3",    1, 0, 1, BR, 32'h60,       0, 32'h0,    32'h20,       32'h24,       32'h60,       0, 0);
    cyc("stall_end", 1, 1, 1, BR, 32'h60,       0, 32'h0,    32'h20,       32'h24,       32'h60,       0, 0);
    cyc("fl_trap",   1, 1, 0, 0,  32'h0,        1, 32'h200,  32'h60,       32'h64,       32'h200,      1, 0);
    cyc("async_rst", 0, 1, 0, 0,  32'h0,        1, 32'h200,  32'h0,        32'h4,        32'h0,        1, 0);
    cyc("reboot",    1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h0,        32'h4,        32'h0,        1, 0);
    cyc("to_top",    1, 1, 1, BR, 32'hFFFFFFFC, 0, 32'h0,    32'h0,        32'h4,        32'hFFFFFFFC, 0, 0);
    cyc("wrap",      1, 1, 0, 0,  32'h0,        0, 32'h0,    32'hFFFFFFFC, 32'h0,        32'h0,        1, 0);
    cyc("wrapped",   1, 1, 0, 0,  32'h0,        0, 32'h0,    32'h0,        32'h4,        32'h4,        0, 0);
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/msrv32_pc_unit.md
MSRV32_PC_UNIT -- requirements
Module: msrv32_pc_unit

Interface
REQ-001 SHALL have parameter BOOT_ADDRESS, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port ms_riscv32_mp_clk_in  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port ms_riscv32_mp_rst_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port branch_taken_in  input  1  branch/jump resolution from msrv32_branch_unit.
REQ-005 SHALL have port opcode_in  input  5 [6:2]  opcode of the instruction in execute.
REQ-006 SHALL have port iaddr_in  input  32  branch/JAL/JALR target from the immediate adder.
REQ-007 SHALL have port ahb_ready_in  input  1  instruction bus ready; 0 = stall.
REQ-008 SHALL have port trap_taken_in  input  1  trap or MRET redirect request.
REQ-009 SHALL have port trap_address_in  input  32  trap vector or MEPC.
REQ-010 SHALL have port pc_out  output  32  registered address of the instruction in execute.
REQ-011 SHALL have port pc_plus_4_out  output  32  pc_out + 4, the link value.
REQ-012 SHALL have port i_addr_out  output  32  fetch address presented to the instruction bus.
REQ-013 SHALL have port misaligned_instr_out  output  1  taken target not 4-byte aligned.
REQ-014 SHALL have port flush_out  output  1  kill the instruction currently fetched.

Function
REQ-015 SHALL implement FSM states BOOT, RUN and FLUSH, held in a registered state variable.
REQ-016 SHALL form target = iaddr_in with bit 0 forced to 0 when opcode_in = 5'b11001 (JALR); otherwise target = iaddr_in.
REQ-017 SHALL assert misaligned_instr_out combinationally when state = RUN, branch_taken_in = 1 and target[1] = 1; otherwise 0.
REQ-018 SHALL compute next_pc with priority trap_taken_in -> trap_address_in; else (RUN, branch_taken_in, not misaligned) -> target; else pc_out + 4.
REQ-019 SHALL compute pc_plus_4_out = pc_out + 4 modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 SHALL drive i_addr_out = BOOT_ADDRESS in BOOT and next_pc in RUN and FLUSH.
REQ-021 SHALL update nothing (pc_out, state) on a clock edge with ahb_ready_in = 0; all outputs then stay stable.
REQ-022 SHALL, in BOOT on an edge with ahb_ready_in = 1, load pc_out <= BOOT_ADDRESS and move to RUN.
REQ-023 SHALL, in RUN on an edge with ahb_ready_in = 1, load pc_out <= next_pc and move to FLUSH on a redirect (trap or taken aligned branch); otherwise stay in RUN.
REQ-024 SHALL, in FLUSH, ignore branch_taken_in (the instruction is killed), still honour trap_taken_in, and on a ready edge load pc_out <= next_pc and return to RUN, or stay in FLUSH if trap_taken_in = 1.
REQ-025 SHALL drive flush_out = 1 in BOOT and FLUSH and 0 in RUN.
REQ-026 SHALL use a misaligned target only to raise misaligned_instr_out; pc_out advances by 4 and the trap unit issues the redirect.
REQ-027 SHALL have a total latency of exactly one ready edge from a redirect input to pc_out showing the new address.

Reset
REQ-028 SHALL, while ms_riscv32_mp_rst_in = 0, immediately and without waiting for a clock force state = BOOT and pc_out = BOOT_ADDRESS.
REQ-029 SHALL drive these output values during reset: pc_plus_4_out = BOOT_ADDRESS + 4, i_addr_out = BOOT_ADDRESS, flush_out = 1, misaligned_instr_out = 0.
REQ-030 SHALL abandon any redirect or stall in progress when reset asserts mid-operation; the first ready edge after release behaves as REQ-022.

Verification
REQ-031 SHALL cover: reset release, ready = 1 for 3 edges -> pc_out 0, 4, 8; flush_out 1 then 0, 0.
REQ-032 SHALL cover: pc_out = 32'h10, opcode 5'b11000, branch_taken_in = 1, iaddr_in = 32'h40 -> pc_out = 32'h40 and flush_out = 1 for one cycle; a branch_taken_in = 1 during that FLUSH cycle is ignored, pc_out = 32'h44.
REQ-033 SHALL cover: opcode 5'b11001, iaddr_in = 32'h81, taken -> pc_out = 32'h80; iaddr_in = 32'h82 -> misaligned_instr_out = 1 and pc_out = old + 4.
REQ-034 SHALL cover: trap_taken_in = 1 with branch_taken_in = 1 in the same cycle, trap_address_in = 32'h100 -> pc_out = 32'h100 (trap wins), then FLUSH.
REQ-035 SHALL cover: ahb_ready_in = 0 for 3 cycles at pc_out = 32'h20 with a pending branch -> pc_out, state and outputs frozen; the redirect is applied on the first ready edge.
REQ-036 SHALL cover: reset asserted asynchronously mid-FLUSH -> pc_out = BOOT_ADDRESS before the next edge; pc_out = 32'hFFFF_FFFC gives pc_plus_4_out = 0.
